// File: rtl/lfo_delay_line.sv
// lfo_delay_line: LFO-modulated fractional delay line (chorus/flanger core).
// Each accepted input sample is written to a circular buffer. The output is
// read back from the buffer at a delay of baseDelay_i samples plus the latched
// LFO offset (Q.6 fixed point).
//
// Build option: define LFO_DELAY_INTERP_EN to interpolate linearly between the
// two neighbouring taps (latency 5). Without it only the integer tap is read
// and the fraction is ignored (latency 4).
//
// Handshake: sampleValid_i is a one-cycle strobe. It is taken only while the
// FSM is IDLE (busy_o low). A strobe that arrives while busy_o is high is
// dropped and sets the sticky overrun_o flag. sampleValid_o is a one-cycle
// strobe with no back-pressure. lfoReq_o pulses once per accepted sample so
// the LFO generator can advance. lfoNew_i may arrive in any cycle.
// The FSM state is visible via busy_o.
module lfo_delay_line #(
    parameter int ADDR_W = 10,   // buffer holds 2^ADDR_W samples; must be >= 7
    parameter int DATA_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic                     sampleValid_i,
    input  logic signed [13:0]       lfoWave_i,
    input  logic                     lfoNew_i,
    input  logic        [ADDR_W-1:0] baseDelay_i,
    output logic                     lfoReq_o,
    output logic signed [DATA_W-1:0] sample_o,
    output logic                     sampleValid_o,
    output logic                     busy_o,
    output logic                     overrun_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int D_W   = ADDR_W + 8;  // signed Q.6 delay width
    localparam int DI_W  = D_W - 6;     // integer part of the delay

    // Clamp keeps the integer delay in [1, DEPTH-2], so neither tap can land
    // on the slot being written in the same accept.
    localparam logic signed [D_W-1:0] D_MIN = D_W'(64);
    localparam logic signed [D_W-1:0] D_MAX = D_W'((DEPTH - 1) * 64 - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        CALC = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t state;

    logic        [DATA_W-1:0] mem [0:DEPTH-1];
    logic        [DATA_W-1:0] rd_data;
    logic        [ADDR_W-1:0] rd_addr;

    logic        [ADDR_W-1:0] wr_ptr;
    logic        [ADDR_W:0]   fill_cnt;
    logic signed [13:0]       lfo_latch;

    logic        [ADDR_W-1:0] a0;
    logic                     tap0_ok;
    logic signed [DATA_W-1:0] s0;

    // Delay computation from the pre-edge LFO latch value
    logic signed [D_W-1:0]    d_raw;
    logic signed [D_W-1:0]    d_clamped;
    logic        [DI_W-1:0]   di;
    logic        [5:0]        frac;
    logic        [ADDR_W:0]   fill_inc;
    logic        [ADDR_W-1:0] a0_next;
    logic                     tap0_next;
    logic                     accept;

    assign accept = rst_n_i && sampleValid_i && (state == IDLE);

`ifdef LFO_DELAY_INTERP_EN
    logic        [5:0]        frac_q;
    logic                     tap1_ok;
    logic                     tap1_next;
    logic signed [DATA_W-1:0] s1;
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W+6:0] diff_ext;
    logic signed [DATA_W+6:0] frac_ext;
    logic signed [DATA_W+6:0] prod;
    logic signed [DATA_W+6:0] step;
    logic signed [DATA_W-1:0] result;
`else
    logic                     frac_unused;
    assign frac_unused = ^frac;
`endif

    // Target delay D = base*64 + lfo, clamped, then split into integer/fraction
    always_comb begin
        d_raw = $signed({2'b00, baseDelay_i, 6'b000000})
              + $signed({{(D_W-14){lfo_latch[13]}}, lfo_latch});
        d_clamped = d_raw;
        if (d_raw < D_MIN) begin
            d_clamped = D_MIN;
        end else if (d_raw > D_MAX) begin
            d_clamped = D_MAX;
        end
        di   = d_clamped[D_W-1:6];
        frac = d_clamped[5:0];
        fill_inc = (fill_cnt == (ADDR_W+1)'(DEPTH)) ? fill_cnt
                                                   : fill_cnt + (ADDR_W+1)'(1);
        a0_next   = wr_ptr - di[ADDR_W-1:0];
        // A tap is real data only if it lies within the samples written so
        // far, counting the one being written now.
        tap0_next = ({1'b0, fill_inc} > di);
    end

`ifdef LFO_DELAY_INTERP_EN
    // Second-tap validity and the interpolation s0 + ((s1-s0)*frac >>> 6)
    always_comb begin
        tap1_next = ({1'b0, fill_inc} > (di + DI_W'(1)));
        diff      = {s1[DATA_W-1], s1} - {s0[DATA_W-1], s0};
        diff_ext  = {{6{diff[DATA_W]}}, diff};
        frac_ext  = {(DATA_W+1)'(0), frac_q};
        prod      = diff_ext * frac_ext;
        step      = prod >>> 6;
        result    = s0 + step[DATA_W-1:0];
    end
`endif

    // Read address: A0 normally, A0-1 while fetching the second tap
    always_comb begin
        rd_addr = a0;
`ifdef LFO_DELAY_INTERP_EN
        if (state == RD1) begin
            rd_addr = a0 - ADDR_W'(1);
        end
`endif
    end

    // Sample buffer: write on accept, registered read with one-cycle latency
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem[wr_ptr] <= sample_i;
        end
        rd_data <= mem[rd_addr];
    end

    // Control FSM, pointers, LFO latch and all registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            fill_cnt      <= '0;
            lfo_latch     <= '0;
            a0            <= '0;
            tap0_ok       <= 1'b0;
            s0            <= '0;
            sample_o      <= '0;
            sampleValid_o <= 1'b0;
            lfoReq_o      <= 1'b0;
            busy_o        <= 1'b0;
            overrun_o     <= 1'b0;
`ifdef LFO_DELAY_INTERP_EN
            frac_q        <= '0;
            tap1_ok       <= 1'b0;
            s1            <= '0;
`endif
        end else begin
            lfoReq_o      <= 1'b0;
            sampleValid_o <= 1'b0;
            if (lfoNew_i) begin
                lfo_latch <= lfoWave_i;
            end
            if (sampleValid_i && (state != IDLE)) begin
                overrun_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sampleValid_i) begin
                        wr_ptr   <= wr_ptr + ADDR_W'(1);
                        fill_cnt <= fill_inc;
                        a0       <= a0_next;
                        tap0_ok  <= tap0_next;
`ifdef LFO_DELAY_INTERP_EN
                        frac_q   <= frac;
                        tap1_ok  <= tap1_next;
`endif
                        lfoReq_o <= 1'b1;
                        busy_o   <= 1'b1;
                        state    <= RD0;
                    end
                end
                RD0: begin
                    state <= RD1;
                end
                RD1: begin
                    s0 <= tap0_ok ? $signed(rd_data) : '0;
`ifdef LFO_DELAY_INTERP_EN
                    state <= CALC;
`else
                    state <= OUT;
`endif
                end
                CALC: begin
`ifdef LFO_DELAY_INTERP_EN
                    s1 <= tap1_ok ? $signed(rd_data) : '0;
`endif
                    state <= OUT;
                end
                OUT: begin
`ifdef LFO_DELAY_INTERP_EN
                    sample_o <= result;
`else
                    sample_o <= s0;
`endif
                    sampleValid_o <= 1'b1;
                    busy_o        <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfo_delay_line.sv
// Testbench for lfo_delay_line. The reference model keeps the full history of
// accepted samples and computes each output from the delay/clamp/interpolation
// rules with plain integer arithmetic. Define LFO_DELAY_INTERP_EN to match
// the interpolating build.
module tb_lfo_delay_line;

`ifdef LFO_DELAY_INTERP_EN
    localparam int LAT      = 5;
    localparam int EXP_RAMP = 7500;
    localparam bit INTERP   = 1'b1;
`else
    localparam int LAT      = 4;
    localparam int EXP_RAMP = 8000;
    localparam bit INTERP   = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sample_in;
    logic        sample_valid_in;
    logic [13:0] lfo_wave;
    logic        lfo_new;
    logic [9:0]  base_delay;
    logic        lfo_req;
    logic [15:0] sample_out;
    logic        sample_valid_out;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    lfo_delay_line #(.ADDR_W(10), .DATA_W(16)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .sample_i      (sample_in),
        .sampleValid_i (sample_valid_in),
        .lfoWave_i     (lfo_wave),
        .lfoNew_i      (lfo_new),
        .baseDelay_i   (base_delay),
        .lfoReq_o      (lfo_req),
        .sample_o      (sample_out),
        .sampleValid_o (sample_valid_out),
        .busy_o        (busy),
        .overrun_o     (overrun)
    );

    // ---------------- scoreboard / model state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    int          hist[$];
    int          m_lfo = 0;
    int          m_ovr = 0;
    int          last_out = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int tap(input int delay);
        int idx;
        idx = hist.size() - 1 - delay;
        return (idx >= 0) ? hist[idx] : 0;
    endfunction

    // Expected output for the newest entry in hist
    function automatic logic [15:0] model_out(input int base, input int lfo);
        int d, di, fr, s0, s1, p, q;
        d = base * 64 + lfo;
        if (d < 64)    d = 64;
        if (d > 65471) d = 65471;
        di = d / 64;
        fr = d % 64;
        s0 = tap(di);
        s1 = tap(di + 1);
        if (!INTERP) return 16'(s0);
        p = (s1 - s0) * fr;
        q = (p >= 0) ? (p / 64) : -((-p + 63) / 64);
        return 16'(s0 + q);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check_idle_zero(input string tag);
        check({tag, "_sample"}, sample_out, 0);
        check({tag, "_valid"}, sample_valid_out, 0);
        check({tag, "_lfo_req"}, lfo_req, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        sample_valid_in = 1'b0;
        lfo_new = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        hist.delete();
        exp_q.delete();
        m_lfo = 0;
        m_ovr = 0;
    endtask

    task automatic set_lfo(input int v);
        @(posedge clk); #1;
        lfo_new  = 1'b1;
        lfo_wave = v[13:0];
        @(posedge clk); #1;
        lfo_new = 1'b0;
        m_lfo = v;
    endtask

    // One accepted sample with a cycle-by-cycle check of the output strobes.
    // poke re-raises sampleValid_i in cycle 2, which must be dropped.
    task automatic run_sample(input logic [15:0] v, input bit with_lfo, input int lfo_val,
                              input bit poke);
        @(posedge clk); #1;
        sample_in = v;
        sample_valid_in = 1'b1;
        lfo_new = with_lfo;
        lfo_wave = lfo_val[13:0];
        hist.push_back(int'($signed(v)));
        exp_q.push_back(model_out(int'(base_delay), m_lfo));
        if (with_lfo) m_lfo = lfo_val;
        for (int c = 1; c <= LAT + 1; c++) begin
            @(posedge clk); #1;
            lfo_new = 1'b0;
            sample_valid_in = (poke && c == 2);
            if (poke && c == 2) sample_in = 16'($urandom_range(0, 65535));
            if (poke && c == 3) m_ovr = 1;
            @(negedge clk);
            check("lfo_req", lfo_req, int'(c == 1));
            check("busy", busy, int'(c >= 1 && c <= LAT - 1));
            check("out_valid", sample_valid_out, int'(c == LAT));
            check("overrun", overrun, m_ovr);
            if (sample_valid_out) begin
                check("sb_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    check("sample_out", sample_out, exp_q.pop_front());
                end
                last_out = sample_out;
            end
        end
        sample_valid_in = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        sample_in = '0;
        sample_valid_in = 1'b0;
        lfo_wave = '0;
        lfo_new = 1'b0;
        base_delay = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fixed delay of 4: four zeros, then each output trails by 4 samples
        base_delay = 10'd4;
        for (int i = 1; i <= 12; i++) begin
            run_sample(16'(i * 100), 1'b0, 0, 1'b0);
            if (i == 5) check("first_real_tap", last_out, 100);
        end

        // Fractional delay 2.5 on a ramp
        apply_reset();
        set_lfo(32);
        base_delay = 10'd2;
        for (int i = 1; i <= 10; i++) run_sample(16'(i * 1000), 1'b0, 0, 1'b0);
        check("ramp_10000", last_out, EXP_RAMP);

        // Minimum clamp: D = 1.0, output equals the previous input; fills buffer
        base_delay = 10'd0;
        set_lfo(-8000);
        for (int i = 0; i < 1100; i++) begin
            run_sample(16'($urandom_range(0, 65535)), 1'b0, 0, 1'b0);
            gap($urandom_range(0, 2));
        end

        // Maximum clamp: Di = 1022, frac = 63, second tap is the oldest entry
        base_delay = 10'd1023;
        set_lfo(8191);
        for (int i = 0; i < 20; i++) run_sample(16'($urandom_range(0, 65535)), 1'b0, 0, 1'b0);

        // Dropped strobe sets sticky overrun; coincident lfoNew uses the old latch
        base_delay = 10'd3;
        run_sample(16'h1234, 1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) run_sample(16'($urandom_range(0, 65535)), 1'b0, 0, 1'b0);
        set_lfo(-100);
        run_sample(16'h4321, 1'b1, 6000, 1'b0);
        run_sample(16'h0777, 1'b0, 0, 1'b0);

        // Randomised operation
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) base_delay = 10'($urandom_range(0, 1023));
            else if ($urandom_range(0, 2) == 0) base_delay = 10'($urandom_range(0, 12));
            if ($urandom_range(0, 4) == 0) set_lfo(int'($urandom_range(0, 16383)) - 8192);
            run_sample(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 16383)) - 8192, 1'($urandom_range(0, 9) == 0));
            gap($urandom_range(0, 3));
        end

        // Reset in cycle 3 aborts the sample without a strobe
        base_delay = 10'd2;
        @(posedge clk); #1;
        sample_in = 16'h7abc;
        sample_valid_in = 1'b1;
        @(posedge clk); #1;
        sample_valid_in = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        hist.delete();
        m_lfo = 0;
        m_ovr = 0;
        @(negedge clk);
        check_idle_zero("abort");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_no_valid", sample_valid_out, 0);
        end
        base_delay = 10'd3;
        run_sample(16'h5555, 1'b0, 0, 1'b0);
        check("post_reset_zero", last_out, 0);
        run_sample(16'h1111, 1'b0, 0, 1'b0);

        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
